adder_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 32-bit carry-lookahead adder among NUM_REQ requesters.
- Accepts operand requests over valid/ready and registers the operands into the adder.
- Captures the sum and carry-out, then returns the result with a requester ID over a single valid/ready response channel.
- The adder sits outside this block: it is driven by add_* outputs and returns results on add_* inputs, purely combinationally.

---
 rtl/adder_share_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Round-robin arbiter/sequencer that time-shares one external combinational
// WIDTH-bit adder among NUM_REQ requesters. A granted request loads the adder
// operand registers, the sum and carry are captured one cycle later, and the
// result is then offered with its requester ID on a valid/ready response channel.
// Optional feature macro: ADDER_SHARE_OVF_EN adds rsp_ovf_o, which reports
// two's-complement signed overflow of the captured sum.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int WIDTH   = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]       req_ci_i,
    output logic [WIDTH-1:0]         add_a_o,
    output logic [WIDTH-1:0]         add_b_o,
    output logic                     add_ci_o,
    input  logic [WIDTH-1:0]         add_s_i,
    input  logic                     add_co_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [WIDTH-1:0]         rsp_sum_o,
    output logic                     rsp_co_o
`ifdef ADDER_SHARE_OVF_EN
    ,
    output logic                     rsp_ovf_o
`endif
);

    localparam logic [1:0]      ST_IDLE = 2'd0;
    localparam logic [1:0]      ST_BUSY = 2'd1;
    localparam logic [1:0]      ST_RESP = 2'd2;
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

    logic [1:0]         state_r;
    logic [1:0]         next_state_s;
    logic [ID_W-1:0]    rr_ptr_r;
    logic               accept_en_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    grant_id_s;
    logic               grant_any_s;
    logic [ID_W-1:0]    cand_s;
    logic               hit_s;
    logic               transfer_s;
    logic [WIDTH-1:0]   add_a_r;
    logic [WIDTH-1:0]   add_b_r;
    logic               add_ci_r;
    logic [ID_W-1:0]    id_r;
    logic [WIDTH-1:0]   sum_r;
    logic               co_r;
    logic               rsp_valid_r;

    // A new request may be taken when idle, or when the pending result leaves this cycle.
    assign accept_en_s = (state_r == ST_IDLE) || ((state_r == ST_RESP) && rsp_ready_i);

    // Round-robin search starting just after the last winner; reset suppresses grants.
    always_comb begin
        grant_s     = {NUM_REQ{1'b0}};
        grant_id_s  = {ID_W{1'b0}};
        grant_any_s = 1'b0;
        cand_s      = {ID_W{1'b0}};
        hit_s       = 1'b0;
        if (accept_en_s && !rst_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand_s          = ID_W'((int'(rr_ptr_r) + 1 + i) % NUM_REQ);
                hit_s           = !grant_any_s && req_valid_i[cand_s];
                grant_s[cand_s] = grant_s[cand_s] | hit_s;
                grant_id_s      = hit_s ? cand_s : grant_id_s;
                grant_any_s     = grant_any_s | hit_s;
            end
        end else begin
            grant_s     = {NUM_REQ{1'b0}};
            grant_any_s = 1'b0;
        end
    end

    assign transfer_s = |(req_valid_i & grant_s);

    // Sequencer: one accept, one adder-settle cycle, then hold the response until taken.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (transfer_s) begin
                    next_state_s = ST_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                next_state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i && transfer_s) begin
                    next_state_s = ST_BUSY;
                end else if (rsp_ready_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Control state: FSM, round-robin pointer and response-valid flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= PTR_RST;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            rsp_valid_r <= (next_state_s == ST_RESP);
            if (transfer_s) begin
                rr_ptr_r <= grant_id_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Operand/ID capture on a transfer; operands otherwise hold so the adder input never glitches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            add_a_r  <= {WIDTH{1'b0}};
            add_b_r  <= {WIDTH{1'b0}};
            add_ci_r <= 1'b0;
            id_r     <= {ID_W{1'b0}};
        end else if (transfer_s) begin
            add_a_r  <= req_a_i[int'(grant_id_s) * WIDTH +: WIDTH];
            add_b_r  <= req_b_i[int'(grant_id_s) * WIDTH +: WIDTH];
            add_ci_r <= req_ci_i[grant_id_s];
            id_r     <= grant_id_s;
        end else begin
            add_a_r  <= add_a_r;
            add_b_r  <= add_b_r;
            add_ci_r <= add_ci_r;
            id_r     <= id_r;
        end
    end

    // Result capture in the settle cycle; held through the response phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_r <= {WIDTH{1'b0}};
            co_r  <= 1'b0;
        end else if (state_r == ST_BUSY) begin
            sum_r <= add_s_i;
            co_r  <= add_co_i;
        end else begin
            sum_r <= sum_r;
            co_r  <= co_r;
        end
    end

`ifdef ADDER_SHARE_OVF_EN
    logic ovf_r;

    // Signed overflow: like-signed operands producing a sum of the other sign.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_r <= 1'b0;
        end else if (state_r == ST_BUSY) begin
            ovf_r <= (add_a_r[WIDTH-1] == add_b_r[WIDTH-1]) &&
                     (add_s_i[WIDTH-1] != add_a_r[WIDTH-1]);
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign rsp_ovf_o = ovf_r;
`endif

    assign req_ready_o = grant_s;
    assign add_a_o     = add_a_r;
    assign add_b_o     = add_b_r;
    assign add_ci_o    = add_ci_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_id_o    = id_r;
    assign rsp_sum_o   = sum_r;
    assign rsp_co_o    = co_r;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the arbiter/response queue.
module tb_adder_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int WIDTH   = 32;

    logic                     clk = 1'b0;
    logic                     rst_i = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a = '0;
    logic [NUM_REQ*WIDTH-1:0] req_b = '0;
    logic [NUM_REQ-1:0]       req_ci = '0;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic                     add_ci;
    logic [WIDTH-1:0]         add_s;
    logic                     add_co;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b0;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_co;
`ifdef ADDER_SHARE_OVF_EN
    logic                     rsp_ovf;
`endif

    // External shared adder, purely combinational.
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};

    adder_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ci_i    (req_ci),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_ci_o    (add_ci),
        .add_s_i     (add_s),
        .add_co_i    (add_co),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_sum_o   (rsp_sum),
        .rsp_co_o    (rsp_co)
`ifdef ADDER_SHARE_OVF_EN
        ,
        .rsp_ovf_o   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Per-requester operands presented on the packed buses.
    logic [WIDTH-1:0] op_a [NUM_REQ];
    logic [WIDTH-1:0] op_b [NUM_REQ];
    logic             op_ci[NUM_REQ];

    // Model: last winner, one operation in the adder, one result awaiting pickup.
    int               m_ptr;
    bit               m_infl;
    int               m_infl_id;
    logic [WIDTH-1:0] m_infl_a;
    logic [WIDTH-1:0] m_infl_b;
    logic             m_infl_ci;
    logic [WIDTH:0]   m_infl_res;
    logic             m_infl_ovf;
    bit               m_have;
    int               m_id;
    logic [WIDTH:0]   m_res;
    logic             m_ovf;

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic step(input logic [NUM_REQ-1:0] vld, input logic rdy, input logic rst);
        logic [NUM_REQ-1:0] exp_gnt;
        int                 g;
        bit                 can;
        @(negedge clk);
        rst_i     = rst;
        req_valid = vld;
        rsp_ready = rdy;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_a[k*WIDTH +: WIDTH] = op_a[k];
            req_b[k*WIDTH +: WIDTH] = op_b[k];
            req_ci[k]               = op_ci[k];
        end
        #1;
        if (rst) begin
            m_ptr  = NUM_REQ - 1;
            m_infl = 1'b0;
            m_have = 1'b0;
        end
        exp_gnt = '0;
        g       = -1;
        can     = !rst && !m_infl && (!m_have || rdy);
        if (can) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                int k = (m_ptr + i) % NUM_REQ;
                if (g < 0 && vld[k[ID_W-1:0]]) g = k;
            end
        end
        if (g >= 0) exp_gnt[g[ID_W-1:0]] = 1'b1;
        check_val("req_ready", 64'(req_ready), 64'(exp_gnt));
        check_val("rsp_valid", 64'(rsp_valid), 64'(m_have));
        if (m_have) begin
            check_val("rsp_id", 64'(rsp_id), 64'(m_id));
            check_val("rsp_sum", 64'(rsp_sum), 64'(m_res[WIDTH-1:0]));
            check_val("rsp_co", 64'(rsp_co), 64'(m_res[WIDTH]));
`ifdef ADDER_SHARE_OVF_EN
            check_val("rsp_ovf", 64'(rsp_ovf), 64'(m_ovf));
`endif
        end
        if (m_infl) begin
            check_val("add_a", 64'(add_a), 64'(m_infl_a));
            check_val("add_b", 64'(add_b), 64'(m_infl_b));
            check_val("add_ci", 64'(add_ci), 64'(m_infl_ci));
        end
        if (!rst) begin
            if (m_have && rdy) m_have = 1'b0;
            if (m_infl) begin
                m_have = 1'b1;
                m_id   = m_infl_id;
                m_res  = m_infl_res;
                m_ovf  = m_infl_ovf;
                m_infl = 1'b0;
            end
            if (g >= 0) begin
                m_infl     = 1'b1;
                m_infl_id  = g;
                m_infl_a   = op_a[g];
                m_infl_b   = op_b[g];
                m_infl_ci  = op_ci[g];
                m_infl_res = {1'b0, op_a[g]} + {1'b0, op_b[g]} + {{WIDTH{1'b0}}, op_ci[g]};
                m_infl_ovf = (op_a[g][WIDTH-1] == op_b[g][WIDTH-1]) &&
                             (m_infl_res[WIDTH-1] != op_a[g][WIDTH-1]);
                m_ptr      = g;
            end
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic randomize_ops();
        for (int k = 0; k < NUM_REQ; k++) begin
            op_a[k]  = rand_op();
            op_b[k]  = rand_op();
            op_ci[k] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        m_ptr = NUM_REQ - 1; m_infl = 1'b0; m_have = 1'b0;
        m_infl_id = 0; m_infl_a = '0; m_infl_b = '0; m_infl_ci = 1'b0;
        m_infl_res = '0; m_infl_ovf = 1'b0; m_id = 0; m_res = '0; m_ovf = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            op_a[k] = '0; op_b[k] = '0; op_ci[k] = 1'b0;
        end

        // Reset state.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0001, 1'b0, 1'b1);

        // Simple add from requester 0, result held one cycle before pickup.
        op_a[0] = 32'h0000_0005; op_b[0] = 32'h0000_0003; op_ci[0] = 1'b0;
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // Carry-out from requester 2.
        op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'h0000_0001; op_ci[2] = 1'b0;
        step(4'b0100, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        // Signed overflow from requester 1.
        op_a[1] = 32'h7FFF_FFFF; op_b[1] = 32'h0000_0001; op_ci[1] = 1'b0;
        step(4'b0010, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        // Fairness: everyone valid, consumer always ready.
        randomize_ops();
        repeat (12) step(4'b1111, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        // Backpressure, then release with requester 1 waiting.
        randomize_ops();
        repeat (7) step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        // Reset while the adder is busy.
        step(4'b0100, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b0);
        repeat (4) step(4'b0000, 1'b1, 1'b0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            randomize_ops();
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 63) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
